bus_memory_responder: RTL

Main-memory side of the snooping coherence bus: it accepts the 16-bit bus messages that processor caches emit on a miss or eviction and answers with the memory copy of the block. A cache that holds the block modified can supply the data instead. Sits between the shared bus and the 16-entry main memory, opposite the per-processor cache controllers. Owns the memory array (4-bit tag address, 8-bit data) and its write port.

---
 rtl/bus_memory_responder_pkg.sv | 34 +++
 rtl/bus_mem_array.sv | 29 ++
 rtl/bus_memory_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bus_memory_responder_pkg.sv
// Shared coherence definitions: bus message codes, bus field positions,
// responder FSM encoding and the memory reset pattern.
package bus_memory_responder_pkg;

  typedef enum logic [1:0] {
    MSG_NOP        = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_WRITE_MISS = 2'b10,
    MSG_WRITE_BACK = 2'b11
  } msg_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int PROC_HI = 15;
  localparam int PROC_LO = 14;
  localparam int MSG_HI  = 13;
  localparam int MSG_LO  = 12;
  localparam int TAG_HI  = 11;
  localparam int TAG_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  localparam int         MEM_DEPTH = 16;
  localparam logic [7:0] MEM_BASE  = 8'h10;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// 16 x 8 main-memory register file: reset loads MEM_BASE + index,
// one synchronous write port, one asynchronous read port.
module bus_mem_array
  import bus_memory_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // NOTE: this array is reset on purpose -- main memory must come up with a
  // known pattern, so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= MEM_BASE + 8'(i);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder of the snooping coherence bus.
// Optional build macro BUSMEM_STATS_EN adds saturating event counters.
module bus_memory_responder
  import bus_memory_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] bus,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic        snoop_hit,
  input  logic [7:0]  snoop_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_proc,
  output logic [3:0]  resp_tag,
  output logic [7:0]  resp_data
`ifdef BUSMEM_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_wbacks,
  output logic [15:0] stat_snoops
`endif
);

  localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

  state_e     state, state_next;
  logic [3:0] cnt;
  msg_e       bus_msg;
  logic       accept, is_miss;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata, mem_rdata;

  assign bus_msg = msg_e'(bus[MSG_HI:MSG_LO]);
  assign accept  = (state == ST_IDLE) && bus_valid && bus_ready;
  assign is_miss = (bus_msg == MSG_READ_MISS) || (bus_msg == MSG_WRITE_MISS);

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = bus[TAG_HI:TAG_LO];
    mem_wdata  = bus[DATA_HI:DATA_LO];
    unique case (state)
      ST_IDLE: begin
        if (accept && is_miss)                   state_next = ST_WAIT;
        if (accept && bus_msg == MSG_WRITE_BACK) mem_we     = 1'b1;
      end
      ST_WAIT: begin
        // An owning cache supplies the block: absorb it, drop the response.
        if (snoop_hit) begin
          mem_we     = 1'b1;
          mem_waddr  = resp_tag;
          mem_wdata  = snoop_data;
          state_next = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_proc  <= '0;
      resp_tag   <= '0;
      resp_data  <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      bus_ready  <= (state_next == ST_IDLE);
      resp_valid <= (state_next == ST_RESP);
      if (accept && is_miss) begin
        resp_proc <= bus[PROC_HI:PROC_LO];
        resp_tag  <= bus[TAG_HI:TAG_LO];
        cnt       <= LATENCY;
      end
      if (state == ST_WAIT && !snoop_hit) begin
        if (cnt != 4'd0) cnt       <= cnt - 4'd1;
        else             resp_data <= mem_rdata;
      end
    end
  end

  bus_mem_array u_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (resp_tag),
    .rdata (mem_rdata)
  );

`ifdef BUSMEM_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_wbacks <= '0;
      stat_snoops <= '0;
    end else begin
      if (state == ST_RESP && resp_ready)       stat_reads  <= sat_inc(stat_reads);
      if (accept && bus_msg == MSG_WRITE_BACK)  stat_wbacks <= sat_inc(stat_wbacks);
      if (state == ST_WAIT && snoop_hit)        stat_snoops <= sat_inc(stat_snoops);
    end
  end
`endif

endmodule
